// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg -- shared definitions for the two-requester ALU arbiter.
//   * FSM state encoding (IDLE=0, EXEC=1, RESP=2)
//   * opcode / operand / result widths
//   * opcode encoding understood by alu8bit
package alu_arb_pkg;

  localparam int OPC_W = 3;
  localparam int OPD_W = 8;
  localparam int RES_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [OPC_W-1:0] OP_ADD = 3'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 3'd1;
  localparam logic [OPC_W-1:0] OP_AND = 3'd2;
  localparam logic [OPC_W-1:0] OP_OR  = 3'd3;
  localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
  localparam logic [OPC_W-1:0] OP_MUL = 3'd5;
  localparam logic [OPC_W-1:0] OP_SHL = 3'd6;
  localparam logic [OPC_W-1:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu_arbiter_alu8bit.sv
// alu8bit -- purely combinational 8-bit ALU used as the arbiter's shared datapath.
// Ports:
//   opcode [2:0]  operation select (see alu_arb_pkg OP_*)
//   in1, in2 [7:0] operands (unsigned)
//   result [15:0] result; 8-bit ops are zero-extended, MUL gives the full product
//   flagc         ADD: carry out, SUB: borrow, SHL/SHR: bit shifted out,
//                 MUL: upper product byte non-zero, logic ops: 0
//   flagz         result == 0
module alu8bit
  import alu_arb_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [OPD_W-1:0] in1,
  input  logic [OPD_W-1:0] in2,
  output logic [RES_W-1:0] result,
  output logic             flagc,
  output logic             flagz
);

  logic [OPD_W:0]   sum9;
  logic [OPD_W:0]   diff9;
  logic [RES_W-1:0] prod;

  assign sum9  = {1'b0, in1} + {1'b0, in2};
  assign diff9 = {1'b0, in1} - {1'b0, in2};
  assign prod  = {8'h00, in1} * {8'h00, in2};

  always_comb begin
    result = '0;
    flagc  = 1'b0;
    unique case (opcode)
      OP_ADD: begin result = {8'h00, sum9[OPD_W-1:0]};  flagc = sum9[OPD_W];  end
      OP_SUB: begin result = {8'h00, diff9[OPD_W-1:0]}; flagc = diff9[OPD_W]; end
      OP_AND: result = {8'h00, in1 & in2};
      OP_OR:  result = {8'h00, in1 | in2};
      OP_XOR: result = {8'h00, in1 ^ in2};
      OP_MUL: begin result = prod; flagc = |prod[RES_W-1:OPD_W]; end
      OP_SHL: begin result = {8'h00, in1[OPD_W-2:0], 1'b0}; flagc = in1[OPD_W-1]; end
      OP_SHR: begin result = {8'h00, 1'b0, in1[OPD_W-1:1]}; flagc = in1[0];       end
      default: ;
    endcase
    flagz = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter -- round-robin arbiter sharing one alu8bit between two requesters.
// Each accepted operation takes three cycles: IDLE (handshake) -> EXEC (ALU runs
// from captured operands, result registered) -> RESP (response held until
// rsp_ready). At most one operation is in flight.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (0/1)
//   reqN_opcode/in1/in2      request payload
//   rsp_valid/ready          response handshake
//   rsp_id/result/flagc/z    response payload (owner id, ALU result, flags)
//   grant_cnt0/1             saturating grant counters (only with ALU_ARB_STATS_EN)
// Build option: define ALU_ARB_STATS_EN to add the grant counters and their ports.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPC_W-1:0] req0_opcode,
  input  logic [OPD_W-1:0] req0_in1,
  input  logic [OPD_W-1:0] req0_in2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPC_W-1:0] req1_opcode,
  input  logic [OPD_W-1:0] req1_in1,
  input  logic [OPD_W-1:0] req1_in2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_flagc,
  output logic             rsp_flagz
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("alu_arbiter: CNT_W must be at least 1");
  end

  arb_state_e       state_q, state_d;
  logic             rr_q, rr_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [OPD_W-1:0] in1_q, in1_d;
  logic [OPD_W-1:0] in2_q, in2_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_flagc_q, rsp_flagc_d;
  logic             rsp_flagz_q, rsp_flagz_d;

  logic             win_valid;
  logic             win_id;
  logic             handshake;

  logic [RES_W-1:0] alu_result;
  logic             alu_flagc;
  logic             alu_flagz;

  // The ALU only ever sees captured registers, never the live request ports.
  alu8bit u_alu (
    .opcode (opc_q),
    .in1    (in1_q),
    .in2    (in2_q),
    .result (alu_result),
    .flagc  (alu_flagc),
    .flagz  (alu_flagz)
  );

  // Winner selection: rr breaks ties, a lone valid requester always wins.
  always_comb begin
    win_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) win_id = rr_q;
    else                          win_id = req1_valid;
  end

  // Ready is suppressed during reset so nothing is captured on the reset edge.
  assign handshake  = !rst && (state_q == IDLE) && win_valid;
  assign req0_ready = handshake && (win_id == 1'b0);
  assign req1_ready = handshake && (win_id == 1'b1);

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    opc_d        = opc_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flagc_d  = rsp_flagc_q;
    rsp_flagz_d  = rsp_flagz_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          opc_d   = win_id ? req1_opcode : req0_opcode;
          in1_d   = win_id ? req1_in1    : req0_in1;
          in2_d   = win_id ? req1_in2    : req0_in2;
          id_d    = win_id;
          rr_d    = ~win_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flagc_d  = alu_flagc;
        rsp_flagz_d  = alu_flagz;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      opc_q        <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flagc_q  <= 1'b0;
      rsp_flagz_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      opc_q        <= opc_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flagc_q  <= rsp_flagc_d;
      rsp_flagz_q  <= rsp_flagz_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flagc  = rsp_flagc_q;
  assign rsp_flagz  = rsp_flagz_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Saturating increment: counters stick at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req0_ready && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (req1_ready && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter -- directed, table-driven bench for alu_arbiter.
// Build option: define ALU_ARB_STATS_EN to also exercise the grant counters.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_opcode, req1_opcode;
  logic [7:0]  req0_in1, req0_in2, req1_in1, req1_in2;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_flagc, rsp_flagz;
`ifdef ALU_ARB_STATS_EN
  logic [1:0]  grant_cnt0, grant_cnt1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opcode (req0_opcode),
    .req0_in1    (req0_in1),
    .req0_in2    (req0_in2),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opcode (req1_opcode),
    .req1_in1    (req1_in1),
    .req1_in2    (req1_in2),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_flagc   (rsp_flagc),
    .rsp_flagz   (rsp_flagz)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1)
`endif
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
    logic        c;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic who, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (who) begin
      req1_valid = 1'b1; req1_opcode = op; req1_in1 = a; req1_in2 = b;
    end else begin
      req0_valid = 1'b1; req0_opcode = op; req0_in1 = a; req0_in2 = b;
    end
  endtask

  // One full operation with rsp_ready=1: grant, EXEC, RESP, retire.
  task automatic run_op(input string nm, input logic who, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] er, input logic ec, input logic ez);
    int w;
    drive(who, op, a, b);
    #1;
    w = 0;
    while (!(who ? req1_ready : req0_ready) && w < 8) begin
      tick();
      w++;
    end
    chk({nm, " grant"}, who ? req1_ready : req0_ready, 1);
    tick();
    if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    chk({nm, " exec rsp_valid"}, rsp_valid, 0);
    chk({nm, " exec readies"}, {req0_ready, req1_ready}, 0);
    tick();
    chk({nm, " rsp_valid"}, rsp_valid, 1);
    chk({nm, " rsp_id"}, rsp_id, who);
    chk({nm, " result"}, rsp_result, er);
    chk({nm, " flags"}, {rsp_flagc, rsp_flagz}, {ec, ez});
    tick();
    chk({nm, " retired"}, rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    int w;

    //              op    a      b      result    c     z
    vecs[0] = '{3'd0, 8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0};
    vecs[1] = '{3'd0, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{3'd1, 8'h10, 8'h20, 16'h00F0, 1'b1, 1'b0};
    vecs[3] = '{3'd1, 8'h33, 8'h33, 16'h0000, 1'b0, 1'b1};
    vecs[4] = '{3'd2, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0};
    vecs[5] = '{3'd3, 8'hF0, 8'h0F, 16'h00FF, 1'b0, 1'b0};
    vecs[6] = '{3'd4, 8'hAA, 8'hAA, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{3'd5, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0};
    vecs[8] = '{3'd6, 8'h81, 8'h00, 16'h0002, 1'b1, 1'b0};
    vecs[9] = '{3'd7, 8'h01, 8'h00, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_opcode = '0; req0_in1 = '0; req0_in2 = '0;
    req1_valid = 1'b0; req1_opcode = '0; req1_in1 = '0; req1_in2 = '0;

    // Reset for two cycles, then idle.
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset readies", {req0_ready, req1_ready}, 0);
    chk("reset rsp_id", rsp_id, 0);
    chk("reset result", rsp_result, 0);
    chk("reset flags", {rsp_flagc, rsp_flagz}, 0);
`ifdef ALU_ARB_STATS_EN
    chk("reset counters", {grant_cnt0, grant_cnt1}, 0);
`endif

    // Contention from reset: grants alternate 0,1,0,1.
    drive(1'b0, 3'd0, 8'h01, 8'h02);
    drive(1'b1, 3'd1, 8'h05, 8'h03);
    for (int k = 0; k < 4; k++) begin
      #1;
      w = 0;
      while (!(req0_ready || req1_ready) && w < 8) begin
        tick();
        #1;
        w++;
      end
      chk($sformatf("contend %0d grant", k), {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
      tick();
      chk($sformatf("contend %0d exec readies", k), {req0_ready, req1_ready}, 0);
      tick();
      chk($sformatf("contend %0d rsp_valid", k), rsp_valid, 1);
      chk($sformatf("contend %0d rsp_id", k), rsp_id, k % 2);
      chk($sformatf("contend %0d result", k), rsp_result, (k % 2) ? 16'h0002 : 16'h0003);
      chk($sformatf("contend %0d resp readies", k), {req0_ready, req1_ready}, 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Table of ALU vectors, alternating requesters.
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), i[0], vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].r, vecs[i].c, vecs[i].z);

    // Backpressure: response held 5 cycles with rsp_ready=0.
    rsp_ready = 1'b0;
    drive(1'b0, 3'd0, 8'h12, 8'h34);
    #1;
    chk("bp grant", req0_ready, 1);
    tick();
    drive(1'b1, 3'd2, 8'hFF, 8'hFF);
    tick();
    held = rsp_result;
    chk("bp first result", rsp_result, 16'h0046);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp hold %0d valid", i), rsp_valid, 1);
      chk($sformatf("bp hold %0d result", i), rsp_result, held);
      chk($sformatf("bp hold %0d id", i), rsp_id, 0);
      chk($sformatf("bp hold %0d readies", i), {req0_ready, req1_ready}, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp still valid", rsp_valid, 1);
    tick();
    chk("bp retired", rsp_valid, 0);
    // Back in IDLE with both valid: rr now points at req1.
    chk("bp idle rr grant", {req1_ready, req0_ready}, 2'b10);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    tick();

    // Reset during EXEC: no response, rr back to 0.
    drive(1'b0, 3'd0, 8'h01, 8'h01);
    #1;
    chk("rstx grant", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h01, 8'h01);
    drive(1'b1, 3'd0, 8'h02, 8'h02);
    #1;
    chk("rstx readies in reset", {req0_ready, req1_ready}, 0);
    tick();
    chk("rstx readies idle in reset", {req0_ready, req1_ready}, 0);
    chk("rstx no response", rsp_valid, 0);
    rst = 1'b0;
    #1;
    chk("rstx rr reset", {req1_ready, req0_ready}, 2'b01);
    req0_valid = 1'b0;
    #1;
    chk("rstx req1 alone", req1_ready, 1);
    run_op("rstx req1 op", 1'b1, 3'd0, 8'h02, 8'h02, 16'h0004, 1'b0, 1'b0);

`ifdef ALU_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      run_op($sformatf("stat%0d", i), 1'b0, 3'd2, 8'h0F, 8'h03, 16'h0003, 1'b0, 1'b0);
    chk("stats cnt0 saturated", grant_cnt0, 2'b11);
    chk("stats cnt1 zero", grant_cnt1, 2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of per-requester grant counters (used only with ALU_ARB_STATS_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  arbiter accepts that requester's operation this cycle.
REQ-006 req0_opcode / req1_opcode  input  3 each  ALU opcode.
REQ-007 req0_in1, req0_in2, req1_in1, req1_in2  input  8 each  ALU operands.
REQ-008 rsp_valid  output  1  response held for the consumer.
REQ-009 rsp_ready  input  1  consumer accepts the response.
REQ-010 rsp_id  output  1  requester that owns the response (0 or 1).
REQ-011 rsp_result  output  16  ALU result.
REQ-012 rsp_flagc / rsp_flagz  output  1 each  ALU carry and zero flags.
REQ-013 grant_cnt0 / grant_cnt1  output  CNT_W each  present only with ALU_ARB_STATS_EN.

Function
REQ-014 FSM states IDLE, EXEC, RESP: IDLE->EXEC on a request handshake, EXEC->RESP unconditionally, RESP->IDLE when rsp_ready=1.
REQ-015 In IDLE, winner: the only valid requester, or the requester selected by round-robin pointer rr when both are valid; no winner if neither is valid.
REQ-016 reqN_ready=1 only in IDLE and only for the winner; the other requester's ready is 0, and both are 0 in EXEC/RESP.
REQ-017 Handshake when valid&&ready: capture opcode, in1, in2 and requester id into registers; rr becomes the non-granted requester.
REQ-018 A requester holds valid and payload stable until ready; dropping valid before ready is legal and the request is not executed.
REQ-019 EXEC: the shared ALU is driven only from the captured registers; result, flagc and flagz are registered at end of EXEC.
REQ-020 Latency: handshake in cycle N -> rsp_valid=1 from cycle N+2, with rsp_id/result/flags stable while rsp_valid=1.
REQ-021 rsp_valid=1 only in RESP; response retires on rsp_valid&&rsp_ready; no new request accepted in that same cycle (throughput max one op per 3 cycles).
REQ-022 rsp_ready is ignored outside RESP.
REQ-023 ALU inputs are the captured registers in every state, so ALU outputs do not depend on live request ports.

Reset
REQ-024 rst=1 at a clock edge: state=IDLE, rr=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flagc=0, rsp_flagz=0, captured operands/opcode=0, grant counters=0.
REQ-025 rst mid-operation (EXEC or RESP) abandons the operation with no response; both reqN_ready are 0 while rst=1.

Configuration
REQ-026 Macro ALU_ARB_STATS_EN: defined -> grant_cnt0/1 ports exist, each incrementing by 1 on its requester's handshake and saturating at all-ones; undefined -> ports and counters absent, all other behaviour identical.

Structure
REQ-027 Shared package alu_arb_pkg holds FSM state encoding (IDLE=0, EXEC=1, RESP=2) and opcode width 3, operand width 8, result width 16.
REQ-028 Exactly one sub-module: existing alu8bit instantiated once as the shared datapath; no other ALU logic in alu_arbiter.

Verification
REQ-029 Reset: rst=1 two cycles, then rst=0 with no requests -> rsp_valid=0, both ready=0, state IDLE, counters 0.
REQ-030 Single request: req0 in1=8'hAA, in2=8'h55, opcode=3'd0, rsp_ready=1 -> req0_ready in cycle N, rsp_valid in N+2, rsp_id=0, result/flags equal standalone alu8bit for those inputs.
REQ-031 Contention: both valid continuously for 4 ops -> grants alternate 0,1,0,1 from reset; rsp_id order matches.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and payload held, both ready=0; rsp_ready=1 -> retire, IDLE next cycle.
REQ-033 Reset mid-EXEC: rst=1 in EXEC -> no response emitted, rr=0, next request from req1 alone granted normally.
REQ-034 With ALU_ARB_STATS_EN, CNT_W=2: 5 grants to req0 -> grant_cnt0=2'b11 (saturated), grant_cnt1=0.
